// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the three memory requesters, the arbiter and the memory macro.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) ();
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic              g_req;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic              g_ack;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        owner;
    logic              busy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, g_req, g_we, g_addr, g_wdata,
        input  f_ack, d_ack, g_ack, rdata, owner, busy
    );

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, g_req, g_we, g_addr, g_wdata,
        input  mem_rdata,
        output f_ack, d_ack, g_ack, rdata, owner, busy,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport memory (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between fetch (F), data (D) and debug (G) requesters
// with a req/ack handshake, multi-cycle read latency and fetch starvation promotion.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LAT     = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(READ_LAT + 1);
    localparam int unsigned STV_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_F    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;
    localparam logic [1:0] OWN_G    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              f_starved;
    logic [1:0]        win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign f_starved = (starve_q == STV_W'(STARVE_LIMIT));

    // G always first; a starved F jumps ahead of D.
    always_comb begin
        win = OWN_NONE;
        if (bus.g_req) begin
            win = OWN_G;
        end else if (bus.d_req && !(f_starved && bus.f_req)) begin
            win = OWN_D;
        end else if (bus.f_req) begin
            win = OWN_F;
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = bus.f_addr;
        sel_wdata = '0;
        case (win)
            OWN_D: begin
                sel_we    = bus.d_we;
                sel_addr  = bus.d_addr;
                sel_wdata = bus.d_wdata;
            end
            OWN_G: begin
                sel_we    = bus.g_we;
                sel_addr  = bus.g_addr;
                sel_wdata = bus.g_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        mem_en_d = mem_en_q;
        mem_we_d = mem_we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (win != OWN_NONE) begin
                    state_d  = ACCESS;
                    owner_d  = win;
                    mem_en_d = 1'b1;
                    mem_we_d = sel_we;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    cnt_d    = sel_we ? CNT_W'(1) : CNT_W'(READ_LAT);
                    if (win == OWN_F) begin
                        starve_d = '0;
                    end else if (bus.f_req && !f_starved) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = DONE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d  = IDLE;
                owner_d  = OWN_NONE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // Async reset kills the strobes immediately, so an in-flight write never lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_NONE;
            cnt_q    <= '0;
            starve_q <= '0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.f_ack     = (state_q == DONE) && (owner_q == OWN_F);
    assign bus.d_ack     = (state_q == DONE) && (owner_q == OWN_D);
    assign bus.g_ack     = (state_q == DONE) && (owner_q == OWN_G);
    assign bus.rdata     = rdata_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: expected acks are queued at stimulus time and
// checked in order as the arbiter acknowledges them.
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W       = 16;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned READ_LAT     = 2;
    localparam int unsigned STARVE_LIMIT = 4;

    typedef struct packed {
        logic [1:0]  who;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .READ_LAT    (READ_LAT),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Memory model: unwritten words return a fixed pattern; one register stage of read delay.
    logic [31:0] wmem    [0:255];
    logic        written [0:255];
    logic [31:0] mem_rd_q;

    function automatic logic [31:0] pattern(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {24'hA50000, a};
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            wmem[bus.mem_addr[7:0]]    <= bus.mem_wdata;
            written[bus.mem_addr[7:0]] <= 1'b1;
        end
        mem_rd_q <= (written[bus.mem_addr[7:0]] === 1'b1) ? wmem[bus.mem_addr[7:0]]
                                                          : pattern(bus.mem_addr[7:0]);
    end
    assign bus.mem_rdata = mem_rd_q;

    function automatic exp_t mk(input logic [1:0] who, input logic chk, input logic [31:0] d);
        exp_t e;
        e.who  = who;
        e.chk  = chk;
        e.data = d;
        return e;
    endfunction

    task automatic monitor();
        exp_t       e;
        logic [1:0] who;
        forever begin
            @(negedge clk);
            if (bus.f_ack || bus.d_ack || bus.g_ack) begin
                checks++;
                if (int'(bus.f_ack) + int'(bus.d_ack) + int'(bus.g_ack) != 1) begin
                    errors++;
                    $display("FAIL ack_onehot: f=%b d=%b g=%b, required exactly one",
                             bus.f_ack, bus.d_ack, bus.g_ack);
                end
                who = bus.g_ack ? 2'd3 : (bus.d_ack ? 2'd2 : 2'd1);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: requester %0d acked, required no ack", who);
                end else begin
                    e = sb.pop_front();
                    if (who !== e.who) begin
                        errors++;
                        $display("FAIL ack_order: got requester %0d, required %0d", who, e.who);
                    end
                    if (e.chk) begin
                        checks++;
                        if (bus.rdata !== e.data) begin
                            errors++;
                            $display("FAIL ack_rdata: got %h, required %h", bus.rdata, e.data);
                        end
                    end
                end
                checks++;
                if (bus.mem_en !== 1'b0) begin
                    errors++;
                    $display("FAIL ack_mem_en: mem_en=%b during ack, required 0", bus.mem_en);
                end
            end
        end
    endtask

    // Hold requests until acked; D re-requests d_repeats extra times before dropping.
    task automatic serve(input string name, input int budget, input int d_repeats);
        int d_left = d_repeats;
        int n = 0;
        while ((bus.f_req || bus.d_req || bus.g_req) && n < budget) begin
            @(negedge clk);
            n++;
            if (bus.f_ack) bus.f_req = 1'b0;
            if (bus.g_ack) bus.g_req = 1'b0;
            if (bus.d_ack) begin
                if (d_left > 0) d_left--;
                else bus.d_req = 1'b0;
            end
        end
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        bus.g_req = 1'b0;
        @(negedge clk);
        checks++;
        if (n >= budget || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_done: %0d acks outstanding after %0d cycles, required 0",
                     name, sb.size(), n);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks += 8;
        if (bus.owner !== 2'd0) begin
            errors++; $display("FAIL reset_owner: got %0d, required 0", bus.owner);
        end
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy);
        end
        if ({bus.f_ack, bus.d_ack, bus.g_ack} !== 3'b000) begin
            errors++; $display("FAIL reset_acks: got %b, required 000",
                               {bus.f_ack, bus.d_ack, bus.g_ack});
        end
        if (bus.mem_en !== 1'b0) begin
            errors++; $display("FAIL reset_mem_en: got %b, required 0", bus.mem_en);
        end
        if (bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL reset_mem_we: got %b, required 0", bus.mem_we);
        end
        if (bus.rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h, required 0", bus.rdata);
        end
        if (bus.mem_addr !== 16'h0) begin
            errors++; $display("FAIL reset_mem_addr: got %h, required 0", bus.mem_addr);
        end
        if (bus.mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_mem_wdata: got %h, required 0", bus.mem_wdata);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_f_read();
        @(negedge clk);
        bus.f_req  = 1'b1;
        bus.f_addr = 16'h0010;
        sb.push_back(mk(2'd1, 1'b1, 32'hDEADBEEF));
        @(posedge clk);
        #1;
        checks += 2;
        if (bus.owner !== 2'd1) begin
            errors++; $display("FAIL fread_grant_owner: got %0d, required 1", bus.owner);
        end
        if (bus.mem_addr !== 16'h0010) begin
            errors++; $display("FAIL fread_mem_addr: got %h, required 0010", bus.mem_addr);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks += 3;
            if (bus.mem_en !== (k < 2)) begin
                errors++; $display("FAIL fread_mem_en[%0d]: got %b, required %b",
                                   k, bus.mem_en, (k < 2));
            end
            if (bus.f_ack !== (k == 2)) begin
                errors++; $display("FAIL fread_f_ack[%0d]: got %b, required %b",
                                   k, bus.f_ack, (k == 2));
            end
            if (bus.owner !== ((k < 3) ? 2'd1 : 2'd0)) begin
                errors++; $display("FAIL fread_owner[%0d]: got %0d, required %0d",
                                   k, bus.owner, (k < 3) ? 1 : 0);
            end
            if (k == 2) bus.f_req = 1'b0;
        end
    endtask

    task automatic test_d_store();
        @(negedge clk);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h0020;
        bus.d_wdata = 32'h12345678;
        sb.push_back(mk(2'd2, 1'b0, 32'h0));
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks += 3;
            if ({bus.mem_en, bus.mem_we} !== ((k == 0) ? 2'b11 : 2'b00)) begin
                errors++; $display("FAIL dstore_strobe[%0d]: got en/we=%b%b, required %b",
                                   k, bus.mem_en, bus.mem_we, (k == 0) ? 2'b11 : 2'b00);
            end
            if (bus.d_ack !== (k == 1)) begin
                errors++; $display("FAIL dstore_d_ack[%0d]: got %b, required %b",
                                   k, bus.d_ack, (k == 1));
            end
            if (k == 0 && {bus.mem_addr, bus.mem_wdata} !== {16'h0020, 32'h12345678}) begin
                errors++; $display("FAIL dstore_bus: got %h/%h, required 0020/12345678",
                                   bus.mem_addr, bus.mem_wdata);
            end
            if (k == 1) begin
                bus.d_req = 1'b0;
                bus.d_we  = 1'b0;
            end
        end
        checks += 2;
        if (wmem[8'h20] !== 32'h12345678) begin
            errors++; $display("FAIL dstore_mem: got %h, required 12345678", wmem[8'h20]);
        end
        if (bus.rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL dstore_rdata: got %h, required deadbeef", bus.rdata);
        end
    endtask

    task automatic test_contention();
        @(negedge clk);
        bus.f_req  = 1'b1;
        bus.f_addr = 16'h0050;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'h0040;
        bus.g_req  = 1'b1;
        bus.g_we   = 1'b0;
        bus.g_addr = 16'h0030;
        sb.push_back(mk(2'd3, 1'b1, pattern(8'h30)));
        sb.push_back(mk(2'd2, 1'b1, pattern(8'h40)));
        sb.push_back(mk(2'd1, 1'b1, pattern(8'h50)));
        serve("contention", 60, 0);
    endtask

    task automatic test_starvation();
        @(negedge clk);
        bus.f_req  = 1'b1;
        bus.f_addr = 16'h0070;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'h0060;
        for (int i = 0; i < 4; i++) sb.push_back(mk(2'd2, 1'b1, pattern(8'h60)));
        sb.push_back(mk(2'd1, 1'b1, pattern(8'h70)));
        sb.push_back(mk(2'd2, 1'b1, pattern(8'h60)));
        serve("starvation", 100, 4);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.g_req   = 1'b1;
        bus.g_we    = 1'b1;
        bus.g_addr  = 16'h0080;
        bus.g_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.mem_en, bus.mem_we, bus.owner} !== 4'b1111) begin
            errors++; $display("FAIL rstmid_access: got en/we/owner=%b%b%0d, required 113",
                               bus.mem_en, bus.mem_we, bus.owner);
        end
        #1 reset = 1'b0;
        #1;
        checks += 3;
        if ({bus.mem_en, bus.mem_we} !== 2'b00) begin
            errors++; $display("FAIL rstmid_strobe: got en/we=%b%b, required 00",
                               bus.mem_en, bus.mem_we);
        end
        if (bus.owner !== 2'd0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_owner: got owner=%0d busy=%b, required 0/0",
                               bus.owner, bus.busy);
        end
        if (bus.g_ack !== 1'b0) begin
            errors++; $display("FAIL rstmid_g_ack: got %b, required 0", bus.g_ack);
        end
        bus.g_req = 1'b0;
        bus.g_we  = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (written[8'h80] === 1'b1) begin
            errors++; $display("FAIL rstmid_no_write: got mem[80]=%h, required untouched",
                               wmem[8'h80]);
        end
        reset = 1'b1;
        bus.f_req  = 1'b1;
        bus.f_addr = 16'h0010;
        sb.push_back(mk(2'd1, 1'b1, 32'hDEADBEEF));
        serve("rstmid_fetch", 20, 0);
    endtask

    task automatic test_cancel();
        @(negedge clk);
        bus.f_req  = 1'b1;
        bus.f_addr = 16'h0090;
        sb.push_back(mk(2'd1, 1'b1, pattern(8'h90)));
        @(posedge clk);
        @(negedge clk);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'h00A0;
        @(negedge clk);
        bus.d_req = 1'b0;
        serve("cancel", 20, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.owner === 2'd2) begin
                errors++; $display("FAIL cancel_no_grant[%0d]: got owner 2, required not 2", k);
            end
        end
    endtask

    initial begin
        bus.f_req   = 1'b0;
        bus.f_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.g_req   = 1'b0;
        bus.g_we    = 1'b0;
        bus.g_addr  = '0;
        bus.g_wdata = '0;
        reset       = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_f_read();
        test_d_store();
        test_contention();
        test_starvation();
        test_reset_mid();
        test_cancel();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
